// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared opcode, funct3 and FSM encodings for branch resolution in ID.
// Also provides the B-type immediate extractor used by the target adder.
package branch_redirect_ctrl_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluation: funct3 plus operands -> taken / illegal.
// Purely combinational; the two reserved funct3 codes are flagged and never taken.
module branch_cmp
  import branch_redirect_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken,
  output logic        illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = !lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = !lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves B-type branches in ID and issues a registered PC redirect to fetch (valid/ready).
// Stalls ID on operand hazards and while a redirect is pending; keeps branch/taken counters.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter bit CHK_AL = 1'b1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_inst,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic             opnd_hazard,
  input  logic             fetch_ready,
  output logic             stall_id,
  output logic             flush_if,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             misalign,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  state_t      state_nx;
  logic        is_br;
  logic [31:0] target;
  logic        cmp_taken;
  logic        cmp_illegal;
  logic        tgt_mis;
  logic        resolve;
  logic        go_redir;
  logic        go_mis;
  logic        unused_inst_bits;

  // Register-index fields are consumed by the forwarding logic, not here.
  assign unused_inst_bits = ^id_inst[24:15];

  assign is_br   = id_valid && (id_inst[6:0] == OPC_BRANCH);
  assign target  = id_pc + b_imm(id_inst);
  assign tgt_mis = CHK_AL && target[1];

  branch_cmp u_cmp (
    .funct3  (id_inst[14:12]),
    .rs1     (rs1_data),
    .rs2     (rs2_data),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  always_comb begin
    state_nx = state;
    stall_id = 1'b0;
    flush_if = 1'b0;
    resolve  = 1'b0;
    go_redir = 1'b0;
    go_mis   = 1'b0;
    case (state)
      ST_IDLE, ST_WAIT: begin
        if (!is_br) begin
          state_nx = ST_IDLE;
        end else if (opnd_hazard) begin
          stall_id = 1'b1;
          state_nx = ST_WAIT;
        end else begin
          resolve  = 1'b1;
          state_nx = ST_IDLE;
          if (cmp_taken) begin
            // A misaligned target raises an exception instead of redirecting.
            if (tgt_mis) begin
              go_mis = 1'b1;
            end else begin
              go_redir = 1'b1;
              flush_if = 1'b1;
              state_nx = ST_REDIR;
            end
          end
        end
      end
      ST_REDIR: begin
        stall_id = 1'b1;
        flush_if = 1'b1;
        if (fetch_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      misalign       <= 1'b0;
      illegal_br     <= 1'b0;
      br_cnt         <= '0;
      taken_cnt      <= '0;
    end else begin
      state      <= state_nx;
      misalign   <= go_mis;
      illegal_br <= resolve && cmp_illegal;
      if (go_redir) begin
        redirect_valid <= 1'b1;
        redirect_pc    <= target;
      end else if (state == ST_REDIR && fetch_ready) begin
        redirect_valid <= 1'b0;
      end
      if (resolve)  br_cnt    <= br_cnt + CNT_ONE;
      if (go_redir) taken_cnt <= taken_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; 4-bit counters so wrap-around is reachable.
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        clrn;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        opnd_hazard;
  logic        fetch_ready;
  logic        stall_id;
  logic        flush_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;
  logic        illegal_br;
  logic [3:0]  br_cnt;
  logic [3:0]  taken_cnt;

  int n_checks = 0;
  int n_errors = 0;

  branch_redirect_ctrl #(.CNT_W(4), .CHK_AL(1'b1)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .opnd_hazard    (opnd_hazard),
    .fetch_ready    (fetch_ready),
    .stall_id       (stall_id),
    .flush_if       (flush_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign       (misalign),
    .illegal_br     (illegal_br),
    .br_cnt         (br_cnt),
    .taken_cnt      (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Encode a B-type instruction from a 13-bit byte offset.
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic hz, input logic rdy);
    id_valid    = v;
    id_pc       = pc;
    id_inst     = inst;
    rs1_data    = a;
    rs2_data    = b;
    opnd_hazard = hz;
    fetch_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, rdy);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b0;
    idle(1'b1);
    tick;
    tick;
    chk("rst_valid", {31'h0, redirect_valid}, 32'h0);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_br", {28'h0, br_cnt}, 32'h0);
    chk("rst_taken", {28'h0, taken_cnt}, 32'h0);
    chk("rst_mis", {31'h0, misalign}, 32'h0);
    chk("rst_ill", {31'h0, illegal_br}, 32'h0);
    chk("rst_stall", {31'h0, stall_id}, 32'h0);
    clrn = 1'b1;

    // beq taken, +16 from 0x100, accepted immediately
    drive(1'b1, 32'h100, enc_b(13'd16, 3'b000), 32'd5, 32'd5, 1'b0, 1'b1);
    #1;
    chk("t1_flush_n", {31'h0, flush_if}, 32'h1);
    chk("t1_stall_n", {31'h0, stall_id}, 32'h0);
    tick;
    chk("t1_valid", {31'h0, redirect_valid}, 32'h1);
    chk("t1_pc", redirect_pc, 32'h110);
    chk("t1_br", {28'h0, br_cnt}, 32'd1);
    chk("t1_taken", {28'h0, taken_cnt}, 32'd1);
    idle(1'b1);
    #1;
    chk("t1_redir_stall", {31'h0, stall_id}, 32'h1);
    chk("t1_redir_flush", {31'h0, flush_if}, 32'h1);
    tick;
    chk("t1_valid_drop", {31'h0, redirect_valid}, 32'h0);
    chk("t1_idle_stall", {31'h0, stall_id}, 32'h0);

    // blt -1 < 1 taken
    drive(1'b1, 32'h200, enc_b(13'd8, 3'b100), 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    #1;
    chk("t2_blt_flush", {31'h0, flush_if}, 32'h1);
    tick;
    chk("t2_blt_pc", redirect_pc, 32'h208);
    chk("t2_blt_valid", {31'h0, redirect_valid}, 32'h1);
    idle(1'b1);
    tick;
    // bltu 0xFFFFFFFF < 1 not taken
    drive(1'b1, 32'h200, enc_b(13'd8, 3'b110), 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    #1;
    chk("t2_bltu_flush", {31'h0, flush_if}, 32'h0);
    chk("t2_bltu_stall", {31'h0, stall_id}, 32'h0);
    tick;
    chk("t2_bltu_valid", {31'h0, redirect_valid}, 32'h0);
    chk("t2_bltu_br", {28'h0, br_cnt}, 32'd3);
    chk("t2_bltu_taken", {28'h0, taken_cnt}, 32'd2);
    // bge 0x80000000 >= 0 (signed) not taken
    drive(1'b1, 32'h200, enc_b(13'd8, 3'b101), 32'h8000_0000, 32'h0, 1'b0, 1'b1);
    #1;
    chk("t2_bge_flush", {31'h0, flush_if}, 32'h0);
    tick;
    chk("t2_bge_br", {28'h0, br_cnt}, 32'd4);
    chk("t2_bge_taken", {28'h0, taken_cnt}, 32'd2);

    // bne from pc 0 with -4 wraps; fetch holds off for 3 cycles, wrong-path branch in ID
    drive(1'b1, 32'h0, enc_b(13'h1FFC, 3'b001), 32'd1, 32'd2, 1'b0, 1'b0);
    tick;
    chk("t3_pc", redirect_pc, 32'hFFFF_FFFC);
    chk("t3_valid", {31'h0, redirect_valid}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold_stall", {31'h0, stall_id}, 32'h1);
      tick;
      chk("t3_hold_valid", {31'h0, redirect_valid}, 32'h1);
      chk("t3_hold_pc", redirect_pc, 32'hFFFF_FFFC);
      chk("t3_hold_br", {28'h0, br_cnt}, 32'd5);
    end
    idle(1'b1);
    tick;
    chk("t3_accept", {31'h0, redirect_valid}, 32'h0);
    chk("t3_taken", {28'h0, taken_cnt}, 32'd3);

    // beq held by operand hazard for 2 cycles
    drive(1'b1, 32'h300, enc_b(13'd32, 3'b000), 32'd7, 32'd7, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t4_hz_stall", {31'h0, stall_id}, 32'h1);
      chk("t4_hz_flush", {31'h0, flush_if}, 32'h0);
      tick;
      chk("t4_hz_br", {28'h0, br_cnt}, 32'd5);
    end
    opnd_hazard = 1'b0;
    #1;
    chk("t4_res_stall", {31'h0, stall_id}, 32'h0);
    chk("t4_res_flush", {31'h0, flush_if}, 32'h1);
    tick;
    chk("t4_br", {28'h0, br_cnt}, 32'd6);
    chk("t4_pc", redirect_pc, 32'h320);
    idle(1'b1);
    tick;

    // reserved funct3 010
    drive(1'b1, 32'h400, enc_b(13'd8, 3'b010), 32'd1, 32'd1, 1'b0, 1'b1);
    tick;
    chk("t5_ill", {31'h0, illegal_br}, 32'h1);
    chk("t5_ill_valid", {31'h0, redirect_valid}, 32'h0);
    chk("t5_ill_br", {28'h0, br_cnt}, 32'd7);
    idle(1'b1);
    tick;
    chk("t5_ill_pulse", {31'h0, illegal_br}, 32'h0);
    // taken to 0x102 is misaligned
    drive(1'b1, 32'h100, enc_b(13'd2, 3'b000), 32'd3, 32'd3, 1'b0, 1'b1);
    #1;
    chk("t5_mis_flush", {31'h0, flush_if}, 32'h0);
    tick;
    chk("t5_mis", {31'h0, misalign}, 32'h1);
    chk("t5_mis_valid", {31'h0, redirect_valid}, 32'h0);
    chk("t5_mis_br", {28'h0, br_cnt}, 32'd8);
    chk("t5_mis_taken", {28'h0, taken_cnt}, 32'd4);
    idle(1'b1);
    tick;
    chk("t5_mis_pulse", {31'h0, misalign}, 32'h0);

    // reset while a redirect is pending
    drive(1'b1, 32'h500, enc_b(13'd4, 3'b000), 32'd0, 32'd0, 1'b0, 1'b0);
    tick;
    chk("t6_pre_valid", {31'h0, redirect_valid}, 32'h1);
    idle(1'b0);
    clrn = 1'b0;
    tick;
    clrn = 1'b1;
    #1;
    chk("t6_valid", {31'h0, redirect_valid}, 32'h0);
    chk("t6_pc", redirect_pc, 32'h0);
    chk("t6_br", {28'h0, br_cnt}, 32'd0);
    chk("t6_taken", {28'h0, taken_cnt}, 32'd0);
    chk("t6_state_idle", {31'h0, stall_id}, 32'h0);

    // non-branch in ID does nothing
    drive(1'b1, 32'h600, 32'h0000_0013, 32'd0, 32'd0, 1'b0, 1'b1);
    #1;
    chk("t7_nb_stall", {31'h0, stall_id}, 32'h0);
    tick;
    chk("t7_nb_br", {28'h0, br_cnt}, 32'd0);

    // 15 not-taken branches fill the 4-bit counter, the 16th wraps it
    drive(1'b1, 32'h700, enc_b(13'd8, 3'b001), 32'd9, 32'd9, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) tick;
    chk("t6_full", {28'h0, br_cnt}, 32'd15);
    tick;
    chk("t6_wrap", {28'h0, br_cnt}, 32'd0);
    chk("t6_wrap_taken", {28'h0, taken_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
